// File: rtl/control_unit_fsm_if.sv
`default_nettype none
// ============================================================================
//  Module      : control_unit_fsm_if
//  Description : Control bus between the instruction sequencer and the
//                memory, PC, register-file and ALU blocks.
//  Revision    : 1.0 - initial release
// ============================================================================
interface control_unit_fsm_if #(
    parameter int OPCODE_W = 5
);
    logic                ENABLE;
    logic [OPCODE_W-1:0] OPCODE;
    logic [3:0]          FLAGS;
    logic                MEM_READY;
    logic                RD_EN;
    logic                WR_EN;
    logic                INC_PC;
    logic                LOAD_REG;
    logic [2:0]          LOAD_SELECT;
    logic                MODE;
    logic                MUX_SELECT_A;
    logic                MUX_SELECT_B;
    logic                INSTR_DONE;
    logic                ILLEGAL;
    logic                BUS_ERR;
    logic                HALTED;

    modport master (
        input  ENABLE, OPCODE, FLAGS, MEM_READY,
        output RD_EN, WR_EN, INC_PC, LOAD_REG, LOAD_SELECT, MODE,
               MUX_SELECT_A, MUX_SELECT_B, INSTR_DONE, ILLEGAL,
               BUS_ERR, HALTED
    );

    modport slave (
        output ENABLE, OPCODE, FLAGS, MEM_READY,
        input  RD_EN, WR_EN, INC_PC, LOAD_REG, LOAD_SELECT, MODE,
               MUX_SELECT_A, MUX_SELECT_B, INSTR_DONE, ILLEGAL,
               BUS_ERR, HALTED
    );
endinterface
`default_nettype wire

// File: rtl/control_unit_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : control_unit_fsm
//  Description : Multi-cycle fetch/decode/execute/memory/writeback sequencer
//                for the 19-bit CPU, with memory-ready timeout.
//  Revision    : 1.0 - initial release
// ============================================================================
module control_unit_fsm #(
    parameter int OPCODE_W    = 5,
    parameter int MEM_TIMEOUT = 15
) (
    input  wire               CLK,
    input  wire               RST,
    control_unit_fsm_if.master bus
);
    localparam int CNT_RAW = $clog2(MEM_TIMEOUT + 1);
    localparam int CNT_W   = (CNT_RAW < 4) ? 4 : CNT_RAW;

    localparam logic [OPCODE_W-1:0] c_op_nop  = OPCODE_W'(5'h00);
    localparam logic [OPCODE_W-1:0] c_op_alu0 = OPCODE_W'(5'h01);
    localparam logic [OPCODE_W-1:0] c_op_log0 = OPCODE_W'(5'h08);
    localparam logic [OPCODE_W-1:0] c_op_logn = OPCODE_W'(5'h0F);
    localparam logic [OPCODE_W-1:0] c_op_lda  = OPCODE_W'(5'h10);
    localparam logic [OPCODE_W-1:0] c_op_ldb  = OPCODE_W'(5'h11);
    localparam logic [OPCODE_W-1:0] c_op_st   = OPCODE_W'(5'h12);
    localparam logic [OPCODE_W-1:0] c_op_jmp  = OPCODE_W'(5'h13);
    localparam logic [OPCODE_W-1:0] c_op_jz   = OPCODE_W'(5'h14);
    localparam logic [OPCODE_W-1:0] c_op_jn   = OPCODE_W'(5'h15);
    localparam logic [OPCODE_W-1:0] c_op_jc   = OPCODE_W'(5'h16);
    localparam logic [OPCODE_W-1:0] c_op_jv   = OPCODE_W'(5'h17);
    localparam logic [OPCODE_W-1:0] c_op_halt = OPCODE_W'(5'h1F);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FETCH     = 3'd1,
        S_DECODE    = 3'd2,
        S_EXECUTE   = 3'd3,
        S_MEM_WAIT  = 3'd4,
        S_WRITEBACK = 3'd5,
        S_HALT      = 3'd6
    } state_t;

    state_t           r_state;
    state_t           w_next;
    state_t           w_go;
    logic [CNT_W-1:0] r_wait_cnt;
    logic             r_bus_err;

    logic w_is_alu, w_is_logic, w_is_mem, w_is_st, w_is_jmp, w_is_jcc;
    logic w_is_halt, w_is_nop, w_illegal, w_flag, w_at_limit, w_timeout;
    logic w_rd_en, w_wr_en, w_inc_pc, w_load_reg, w_mode;
    logic w_mux_a, w_mux_b, w_done, w_ill;
    logic [2:0] w_load_sel;

    assign w_is_alu   = (bus.OPCODE >= c_op_alu0) && (bus.OPCODE <= c_op_logn);
    assign w_is_logic = (bus.OPCODE >= c_op_log0) && (bus.OPCODE <= c_op_logn);
    assign w_is_st    = (bus.OPCODE == c_op_st);
    assign w_is_mem   = (bus.OPCODE == c_op_lda) || (bus.OPCODE == c_op_ldb) || w_is_st;
    assign w_is_jmp   = (bus.OPCODE == c_op_jmp);
    assign w_is_jcc   = (bus.OPCODE >= c_op_jz) && (bus.OPCODE <= c_op_jv);
    assign w_is_halt  = (bus.OPCODE == c_op_halt);
    assign w_is_nop   = (bus.OPCODE == c_op_nop);
    assign w_illegal  = !(w_is_nop || w_is_alu || w_is_mem || w_is_jmp ||
                          w_is_jcc || w_is_halt);
    assign w_at_limit = (r_wait_cnt == CNT_W'(MEM_TIMEOUT - 1));

    always_comb begin
        w_flag = 1'b0;
        case (bus.OPCODE)
            c_op_jz: w_flag = bus.FLAGS[0];
            c_op_jn: w_flag = bus.FLAGS[1];
            c_op_jc: w_flag = bus.FLAGS[2];
            c_op_jv: w_flag = bus.FLAGS[3];
            default: w_flag = 1'b0;
        endcase
    end

    always_comb begin
        w_next     = r_state;
        w_timeout  = 1'b0;
        w_rd_en    = 1'b0;
        w_wr_en    = 1'b0;
        w_inc_pc   = 1'b0;
        w_load_reg = 1'b0;
        w_load_sel = 3'b000;
        w_mode     = 1'b0;
        w_mux_a    = 1'b0;
        w_mux_b    = 1'b0;
        w_done     = 1'b0;
        w_ill      = 1'b0;
        // A dropped ENABLE lets the instruction finish, then parks in IDLE.
        w_go       = bus.ENABLE ? S_FETCH : S_IDLE;

        case (r_state)
            S_IDLE: begin
                if (bus.ENABLE) w_next = S_FETCH;
            end
            S_FETCH: begin
                w_rd_en = 1'b1;
                if (bus.MEM_READY) begin
                    w_load_reg = 1'b1;
                    w_load_sel = 3'b001;
                    w_inc_pc   = 1'b1;
                    w_next     = S_DECODE;
                end else if (w_at_limit) begin
                    w_timeout = 1'b1;
                    w_next    = S_HALT;
                end
            end
            S_DECODE: begin
                if (w_is_halt) begin
                    w_done = 1'b1;
                    w_next = S_HALT;
                end else if (w_is_alu) begin
                    w_next = S_EXECUTE;
                end else if (w_is_mem) begin
                    w_next = S_MEM_WAIT;
                end else if (w_is_jmp || (w_is_jcc && w_flag)) begin
                    w_next = S_EXECUTE;
                end else begin
                    w_done = 1'b1;
                    w_ill  = w_illegal;
                    w_next = w_go;
                end
            end
            S_EXECUTE: begin
                if (w_is_alu) begin
                    w_mode  = w_is_logic;
                    w_mux_a = 1'b1;
                    w_mux_b = 1'b1;
                    w_next  = S_WRITEBACK;
                end else begin
                    w_load_reg = 1'b1;
                    w_load_sel = 3'b000;
                    w_done     = 1'b1;
                    w_next     = w_go;
                end
            end
            S_WRITEBACK: begin
                w_load_reg = 1'b1;
                w_load_sel = 3'b100;
                w_done     = 1'b1;
                w_next     = w_go;
            end
            S_MEM_WAIT: begin
                w_mux_a = 1'b1;
                w_rd_en = !w_is_st;
                w_wr_en = w_is_st;
                if (bus.MEM_READY) begin
                    if (!w_is_st) begin
                        w_load_reg = 1'b1;
                        w_load_sel = (bus.OPCODE == c_op_lda) ? 3'b010 : 3'b011;
                    end
                    w_done = 1'b1;
                    w_next = w_go;
                end else if (w_at_limit) begin
                    w_timeout = 1'b1;
                    w_next    = S_HALT;
                end
            end
            S_HALT: begin
                if (!bus.ENABLE) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state    <= S_IDLE;
            r_wait_cnt <= '0;
            r_bus_err  <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_timeout) r_bus_err <= 1'b1;
            if (w_next != r_state)
                r_wait_cnt <= '0;
            else if (((r_state == S_FETCH) || (r_state == S_MEM_WAIT)) && !bus.MEM_READY)
                r_wait_cnt <= r_wait_cnt + 1'b1;
        end
    end

    assign bus.RD_EN        = w_rd_en;
    assign bus.WR_EN        = w_wr_en;
    assign bus.INC_PC       = w_inc_pc;
    assign bus.LOAD_REG     = w_load_reg;
    assign bus.LOAD_SELECT  = w_load_sel;
    assign bus.MODE         = w_mode;
    assign bus.MUX_SELECT_A = w_mux_a;
    assign bus.MUX_SELECT_B = w_mux_b;
    assign bus.INSTR_DONE   = w_done;
    assign bus.ILLEGAL      = w_ill;
    assign bus.BUS_ERR      = r_bus_err;
    assign bus.HALTED       = (r_state == S_HALT);
endmodule
`default_nettype wire

// File: tb/tb_control_unit_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : tb_control_unit_fsm
//  Description : Directed self-checking bench for control_unit_fsm.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_control_unit_fsm;
    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 clk = ~clk;

    control_unit_fsm_if #(.OPCODE_W(5)) bus ();

    control_unit_fsm #(.OPCODE_W(5), .MEM_TIMEOUT(15)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    // {RD,WR,INC,LD,SEL[2:0],MODE,MA,MB,DONE,ILL,BERR,HALT}
    logic [13:0] outs;
    assign outs = {bus.RD_EN, bus.WR_EN, bus.INC_PC, bus.LOAD_REG, bus.LOAD_SELECT,
                   bus.MODE, bus.MUX_SELECT_A, bus.MUX_SELECT_B, bus.INSTR_DONE,
                   bus.ILLEGAL, bus.BUS_ERR, bus.HALTED};

    function automatic logic [13:0] ov(input logic rd, input logic wr, input logic inc,
                                       input logic ld, input logic [2:0] sel,
                                       input logic mode, input logic ma, input logic mb,
                                       input logic done, input logic ill,
                                       input logic berr, input logic halt);
        return {rd, wr, inc, ld, sel, mode, ma, mb, done, ill, berr, halt};
    endfunction

    task automatic check(input string tag, input logic [13:0] got, input logic [13:0] want);
        n_checks++;
        if (got !== want)
            $display("FAIL %s: got %b want %b", tag, got, want);
        else
            n_pass++;
    endtask

    // Check the current state's outputs, then advance one clock.
    task automatic cyc(input string tag, input logic [13:0] want);
        #1;
        check(tag, outs, want);
        @(posedge clk);
        #1;
    endtask

    logic [13:0] e_zero, e_fetch, e_exec_ar, e_exec_lg, e_wb, e_jmp, e_nodone;
    logic [13:0] e_ldwait, e_lda_rdy, e_st_wait, e_halt, e_ill;

    initial begin
        e_zero    = '0;
        e_fetch   = ov(1,0,1,1,3'b001,0,0,0,0,0,0,0);
        e_exec_ar = ov(0,0,0,0,3'b000,0,1,1,0,0,0,0);
        e_exec_lg = ov(0,0,0,0,3'b000,1,1,1,0,0,0,0);
        e_wb      = ov(0,0,0,1,3'b100,0,0,0,1,0,0,0);
        e_jmp     = ov(0,0,0,1,3'b000,0,0,0,1,0,0,0);
        e_nodone  = ov(0,0,0,0,3'b000,0,0,0,1,0,0,0);
        e_ldwait  = ov(1,0,0,0,3'b000,0,1,0,0,0,0,0);
        e_lda_rdy = ov(1,0,0,1,3'b010,0,1,0,1,0,0,0);
        e_st_wait = ov(0,1,0,0,3'b000,0,1,0,0,0,0,0);
        e_halt    = ov(0,0,0,0,3'b000,0,0,0,0,0,0,1);
        e_ill     = ov(0,0,0,0,3'b000,0,0,0,1,1,0,0);

        rst           = 1'b1;
        bus.ENABLE    = 1'b0;
        bus.OPCODE    = 5'h00;
        bus.FLAGS     = 4'h0;
        bus.MEM_READY = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_hold", outs, e_zero);
        rst = 1'b0;

        // ALU arithmetic 0x03, ready tied high
        bus.ENABLE = 1'b1; bus.OPCODE = 5'h03; bus.MEM_READY = 1'b1;
        cyc("post_rst_idle", e_zero);
        cyc("alu_fetch", e_fetch);
        cyc("alu_decode", e_zero);
        cyc("alu_exec", e_exec_ar);
        cyc("alu_wb", e_wb);

        // LDA with three wait cycles
        bus.OPCODE = 5'h10;
        cyc("lda_fetch", e_fetch);
        cyc("lda_decode", e_zero);
        bus.MEM_READY = 1'b0;
        for (int i = 0; i < 3; i++) cyc("lda_wait", e_ldwait);
        bus.MEM_READY = 1'b1;
        cyc("lda_ready", e_lda_rdy);

        // JZ taken; flag drops after decode and must not matter
        bus.OPCODE = 5'h14; bus.FLAGS = 4'b0001;
        cyc("jz_t_fetch", e_fetch);
        cyc("jz_t_decode", e_zero);
        bus.FLAGS = 4'b0000;
        cyc("jz_t_exec", e_jmp);

        // JZ untaken
        cyc("jz_u_fetch", e_fetch);
        cyc("jz_u_decode", e_nodone);

        // ALU logic 0x0A
        bus.OPCODE = 5'h0A;
        cyc("log_fetch", e_fetch);
        cyc("log_decode", e_zero);
        cyc("log_exec", e_exec_lg);
        cyc("log_wb", e_wb);

        // Illegal opcode, then HALT
        bus.OPCODE = 5'h1A;
        cyc("ill_fetch", e_fetch);
        cyc("ill_decode", e_ill);
        bus.OPCODE = 5'h1F;
        cyc("halt_fetch", e_fetch);
        cyc("halt_decode", e_nodone);
        cyc("halt_hold", e_halt);
        bus.ENABLE = 1'b0;
        cyc("halt_exit", e_halt);
        cyc("halt_idle", e_zero);

        // ENABLE dropped during EXECUTE: writeback completes, then IDLE
        bus.ENABLE = 1'b1; bus.OPCODE = 5'h01;
        cyc("en_idle", e_zero);
        cyc("en_fetch", e_fetch);
        cyc("en_decode", e_zero);
        bus.ENABLE = 1'b0;
        cyc("en_exec", e_exec_ar);
        cyc("en_wb", e_wb);
        cyc("en_parked", e_zero);

        // Asynchronous reset in MEM_WAIT
        bus.ENABLE = 1'b1; bus.OPCODE = 5'h11;
        cyc("rst_idle0", e_zero);
        cyc("ldb_fetch", e_fetch);
        cyc("ldb_decode", e_zero);
        bus.MEM_READY = 1'b0;
        cyc("ldb_wait", e_ldwait);
        rst = 1'b1;
        #1;
        check("rst_async", outs, e_zero);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // ST with memory never ready: timeout into HALT with BUS_ERR
        bus.OPCODE = 5'h12; bus.MEM_READY = 1'b1;
        cyc("st_idle", e_zero);
        cyc("st_fetch", e_fetch);
        cyc("st_decode", e_zero);
        bus.MEM_READY = 1'b0;
        for (int i = 0; i < 15; i++) cyc("st_wait", e_st_wait);
        cyc("st_berr_halt", ov(0,0,0,0,3'b000,0,0,0,0,0,1,1));
        bus.ENABLE = 1'b0;
        cyc("st_berr_exit", ov(0,0,0,0,3'b000,0,0,0,0,0,1,1));
        cyc("st_berr_idle", ov(0,0,0,0,3'b000,0,0,0,0,0,1,0));
        cyc("st_berr_sticky", ov(0,0,0,0,3'b000,0,0,0,0,0,1,0));
        rst = 1'b1;
        #1;
        check("berr_clear", outs, e_zero);
        @(posedge clk);
        #1;
        rst = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/control_unit_fsm.md
# control_unit_fsm

Multi-cycle instruction sequencer for the 19-bit CPU. It drives the CU side of the control bus, which is read by memory, PC, register-file and ALU blocks. It steps each instruction through fetch, decode, execute, memory and writeback. It waits on a memory-ready handshake with a timeout, and it resolves conditional branches from the ALU flags.

## Interface
Parameters:
- OPCODE_W, 5: opcode width; OPCODE is taken from IR[18:14].
- MEM_TIMEOUT, 15: maximum cycles to wait for MEM_READY before a bus error.

Ports:
- CLK  input  1  system clock; all state updates on rising edge.
- RST  input  1  asynchronous, active-high reset.
- ENABLE  input  1  run request.
- OPCODE  input  OPCODE_W  opcode field of the IR; valid from DECODE onward.
- FLAGS  input  4  ALU flags {V,C,N,Z}; Z=FLAGS[0], N=[1], C=[2], V=[3].
- MEM_READY  input  1  memory completes the current RD_EN/WR_EN access this cycle.
- RD_EN, WR_EN  output  1  memory read / write request.
- INC_PC  output  1  PC increment strobe.
- LOAD_REG  output  1  load strobe for the register named by LOAD_SELECT.
- LOAD_SELECT  output  3  000 PC, 001 IR, 010 RegA, 011 RegB, 100 RegC.
- MODE  output  1  ALU mode: 0 arithmetic, 1 logic.
- MUX_SELECT_A  output  1  address/operand-A source: 0 PC, 1 RegA/operand.
- MUX_SELECT_B  output  1  operand-B source: 0 immediate, 1 RegB.
- INSTR_DONE  output  1  one-cycle pulse when an instruction retires.
- ILLEGAL  output  1  one-cycle pulse in DECODE for an unmapped opcode.
- BUS_ERR  output  1  sticky; set on memory timeout, cleared only by RST.
- HALTED  output  1  high while in HALT.

## Operation
- The state register has 7 states: IDLE, FETCH, DECODE, EXECUTE, MEM_WAIT, WRITEBACK, HALT. The encoding is 3 bits.
- Outputs are combinational from the current state, OPCODE, FLAGS and MEM_READY. Any output not listed for a state is 0.
- Opcode map:
  - 0x00 NOP.
  - 0x01–0x07 ALU arithmetic, MODE=0.
  - 0x08–0x0F ALU logic, MODE=1.
  - 0x10 LDA (mem→RegA), 0x11 LDB (mem→RegB), 0x12 ST (RegC→mem).
  - 0x13 JMP, 0x14 JZ, 0x15 JN, 0x16 JC, 0x17 JV.
  - 0x1F HALT.
  - All others are illegal and are treated as NOP.
- IDLE: ENABLE=1 → FETCH.
- FETCH: RD_EN=1, MUX_SELECT_A=0. On MEM_READY the block asserts LOAD_REG=1, LOAD_SELECT=001 and INC_PC=1, then goes to DECODE.
- DECODE:
  - NOP/illegal: INSTR_DONE, go to FETCH. ILLEGAL is also pulsed for an illegal opcode.
  - HALT: INSTR_DONE, go to HALT.
  - ALU opcode: go to EXECUTE.
  - LDA/LDB/ST: go to MEM_WAIT.
  - JMP, or a Jcc whose flag is 1: go to EXECUTE.
  - Jcc whose flag is 0: INSTR_DONE, go to FETCH.
- EXECUTE:
  - ALU opcode: MODE per map, MUX_SELECT_A=1, MUX_SELECT_B=1, go to WRITEBACK.
  - Jump: LOAD_REG=1, LOAD_SELECT=000, INSTR_DONE, go to FETCH.
- WRITEBACK: LOAD_REG=1, LOAD_SELECT=100, INSTR_DONE, go to FETCH.
- MEM_WAIT:
  - MUX_SELECT_A=1, plus RD_EN=1 (LDA/LDB) or WR_EN=1 (ST).
  - On MEM_READY for a load: LOAD_REG=1, LOAD_SELECT=010 (LDA) or 011 (LDB).
  - On MEM_READY: INSTR_DONE, go to FETCH.
- HALT: HALTED=1. ENABLE=0 → IDLE.
- ENABLE=0 while mid-instruction: the current instruction completes. Every transition that would enter FETCH enters IDLE instead.
- Wait counter (4 bits minimum):
  - Clears on entry to FETCH or MEM_WAIT.
  - Increments each cycle the state is held without MEM_READY.
  - Reaching MEM_TIMEOUT sets BUS_ERR and forces HALT, with no register load.
- RD_EN and WR_EN are never both 1.

## Timing
- Reset: state=IDLE, wait counter=0, BUS_ERR=0. As a result, every output is 0 while RST is high and in the first cycle after release.
- IDLE→FETCH takes 1 cycle after ENABLE is sampled high.
- Latencies with MEM_READY tied high (FETCH to retire, inclusive):
  - ALU: 4 cycles.
  - LD/ST: 3 cycles.
  - Taken jump: 3 cycles.
  - Untaken jump, NOP or HALT: 2 cycles.
- Each memory wait cycle adds 1 cycle of latency.
- FLAGS are sampled in DECODE only. A flag change afterwards does not alter the branch decision.
- RST asserted in any state returns the block to IDLE immediately. Outputs drop in the same cycle.

## Test plan
- Reset, then ENABLE=1, OPCODE=0x03, MEM_READY=1 → outputs:
  - FETCH: RD_EN, then LOAD_SELECT=001 with INC_PC.
  - EXECUTE: MODE=0.
  - WRITEBACK: LOAD_SELECT=100.
  - INSTR_DONE in cycle 4.
- LDA with MEM_READY low for 3 cycles in MEM_WAIT → RD_EN held 4 cycles; LOAD_SELECT=010 pulses on the ready cycle only.
- JZ with FLAGS=0001 → LOAD_SELECT=000 pulse, 3 cycles. JZ with FLAGS=0000 → no PC load, retires in 2 cycles.
- ST with MEM_READY stuck low → WR_EN held for 15 cycles, then BUS_ERR=1 and HALTED=1. BUS_ERR stays 1 after ENABLE drops, until RST.
- OPCODE=0x1A → ILLEGAL pulse in DECODE; next state FETCH. OPCODE=0x1F → HALTED=1 until ENABLE=0, then IDLE.
- Cases at instruction boundaries:
  - ENABLE dropped during EXECUTE of an ALU op → WRITEBACK completes, then IDLE.
  - RST pulsed during MEM_WAIT → all outputs 0 in the same cycle.
